rob_multi_commit: RTL and testbench
===================================

Name: rob_multi_commit

Overview:
- Parametrised reorder buffer for the fcpu out-of-order core.
- Single-issue dispatch and in-order retirement of up to COMMIT_W entries per cycle.
- Accepts N_CDB result buses per cycle, forwards same-cycle CDB results on its operand read ports, and tracks occupancy and per-entry exceptions.
- Sits between decode/dispatch, the reservation stations (operand lookup), the CDB arbiters and the commit unit.

Parameters:
- DEPTH_W, 4, log2 of entry count (DEPTH = 2**DEPTH_W, DEPTH_W >= 2)
- DATA_W, 32, result width
- REG_ADDR_W, 6, destination register address width
- OPCODE_W, 32, opcode width
- N_READ, 6, operand read ports
- N_CDB, 2, CDB write ports
- COMMIT_W, 2, max retirements per cycle (1..DEPTH)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-high
- i_valid  in  1  dispatch request
- i_ready  out  1  dispatch accept
- i_rsv_id  out  DEPTH_W  id assigned to dispatched entry (= tail)
- i_dst_reg  in  REG_ADDR_W  destination register
- i_no_wait  in  1  entry ready at dispatch (store/jump)
- i_opcode  in  OPCODE_W  opcode
- rd_id  in  N_READ*DEPTH_W  read port ids
- rd_data  out  N_READ*DATA_W  read port data
- rd_filled  out  N_READ  read port data valid
- cdb_valid  in  N_CDB  CDB lane valid
- cdb_id  in  N_CDB*DEPTH_W  CDB lane target id
- cdb_data  in  N_CDB*DATA_W  CDB lane result
- cdb_exception  in  N_CDB  CDB lane raised exception
- clear  in  1  flush all entries (branch mispredict/exception)
- o_valid  out  COMMIT_W  commit lane valid (prefix-contiguous)
- o_ready  in  1  committer accepts all asserted lanes
- o_rob_id, o_dst_reg, o_opcode, o_data, o_exception  out  COMMIT_W*(DEPTH_W, REG_ADDR_W, OPCODE_W, DATA_W, 1)  per-lane entry fields
- count  out  DEPTH_W+1  occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Entry state: valid, ready, exception, dst_reg, opcode, data. Pointers: head, tail (DEPTH_W, wrap modulo DEPTH). count register.
- Reset (nrst=1 at clk edge): all entries cleared, head=tail=count=0. Outputs after reset: i_ready=1, i_rsv_id=0, o_valid=0, rd_filled=0, rd_data=0, count=0, empty=1, full=0.
- i_ready = !full && !clear, from registered count only. No dispatch into a full buffer even when a commit occurs that cycle.
- Dispatch (i_valid && i_ready): entry[tail] <= {valid=1, ready=i_no_wait, exception=0, data=0, fields}; tail+1 wraps DEPTH-1 -> 0. Visible on read/commit from the next cycle.
- CDB lane k writes entry[cdb_id] only if that entry is valid at the current edge: ready=1, data, exception|=cdb_exception. CDB to an invalid id is ignored.
- Two lanes targeting the same id in one cycle: higher lane index wins data; exceptions OR.
- Commit lane j valid iff entry[head+j] is valid&&ready, all lanes <j are valid, and no lane <j has exception. An exception entry is therefore the last valid lane.
- On o_ready: head += n, where n = number of asserted o_valid bits; those entries are invalidated.
- count_next = count + dispatched - n.
- Earliest commit: a CDB write at edge t gives commit visible during cycle t+1 (no CDB-to-commit bypass).
- Read port i: if any cdb lane is valid with cdb_id==rd_id and entry[rd_id] is valid, output that lane's data (highest lane wins) with filled=1. Otherwise output entry data/ready. An invalid entry reads filled=0, data=0. Read is combinational.
- clear has priority over dispatch, CDB and commit: at the next edge all entries are invalid, head=tail=count=0. o_valid is still driven combinationally during the clear cycle, but any commit that cycle is dropped by the ROB. The committer must not assert o_ready together with clear.
- Reset mid-operation: same as clear, and additionally overrides clear.

Test Plan:
- DEPTH_W=2, dispatch 4 with i_no_wait=0 -> i_rsv_id 0,1,2,3; full=1, i_ready=0, count=4; 5th i_valid ignored, tail stays 0.
- Entries 0..3 waiting. CDB lane0 id1 data 0xAA, then id0 data 0x55; o_ready=1 -> cycle after id0 write o_valid=2'b11, o_data={0xAA,0x55}, head=2, count=2.
- Entry 0 completed with cdb_exception=1, entry 1 ready -> o_valid=2'b01, o_exception[0]=1; committer asserts clear -> next cycle empty=1, head=tail=0.
- rd_id=2 waiting, same cycle cdb_valid lane1 id2 data 0x1234 -> rd_filled=1, rd_data=0x1234 combinationally; next cycle still filled from stored value.
- Full buffer, head entry ready, o_ready=1 and i_valid=1 -> commit occurs, dispatch refused, count=3; the following cycle dispatch accepted at wrapped tail 0.
- Both CDB lanes to id 3 with data 0x1/0x2, lane0 exception=1 -> entry 3 data=0x2, exception=1. CDB to invalid id 1 -> no change, rd_filled=0.

Source files
------------

// File: rtl/rob_multi_commit.sv
// Reorder buffer: single-issue dispatch, N_CDB result write-back lanes, forwarding operand
// read ports and in-order retirement of up to COMMIT_W entries per cycle.
module rob_multi_commit #(
  parameter int unsigned DEPTH_W    = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 6,
  parameter int unsigned OPCODE_W   = 32,
  parameter int unsigned N_READ     = 6,
  parameter int unsigned N_CDB      = 2,
  parameter int unsigned COMMIT_W   = 2
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           i_valid,
  output logic                           i_ready,
  output logic [DEPTH_W-1:0]             i_rsv_id,
  input  logic [REG_ADDR_W-1:0]          i_dst_reg,
  input  logic                           i_no_wait,
  input  logic [OPCODE_W-1:0]            i_opcode,
  input  logic [N_READ*DEPTH_W-1:0]      rd_id,
  output logic [N_READ*DATA_W-1:0]       rd_data,
  output logic [N_READ-1:0]              rd_filled,
  input  logic [N_CDB-1:0]               cdb_valid,
  input  logic [N_CDB*DEPTH_W-1:0]       cdb_id,
  input  logic [N_CDB*DATA_W-1:0]        cdb_data,
  input  logic [N_CDB-1:0]               cdb_exception,
  input  logic                           clear,
  output logic [COMMIT_W-1:0]            o_valid,
  input  logic                           o_ready,
  output logic [COMMIT_W*DEPTH_W-1:0]    o_rob_id,
  output logic [COMMIT_W*REG_ADDR_W-1:0] o_dst_reg,
  output logic [COMMIT_W*OPCODE_W-1:0]   o_opcode,
  output logic [COMMIT_W*DATA_W-1:0]     o_data,
  output logic [COMMIT_W-1:0]            o_exception,
  output logic [DEPTH_W:0]               count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_W;

  logic                  valid_q [DEPTH];
  logic                  ready_q [DEPTH];
  logic                  exc_q   [DEPTH];
  logic [DATA_W-1:0]     data_q  [DEPTH];
  logic [REG_ADDR_W-1:0] dst_q   [DEPTH];
  logic [OPCODE_W-1:0]   op_q    [DEPTH];
  logic [DEPTH_W-1:0]    head_q, tail_q;
  logic [DEPTH_W:0]      count_q, count_d;

  logic                  cdb_hit   [DEPTH];
  logic                  cdb_exc   [DEPTH];
  logic [DATA_W-1:0]     cdb_wdata [DEPTH];
  logic [DEPTH_W:0]      commit_n;
  logic                  dispatch;

  assign count    = count_q;
  assign full     = (count_q == (DEPTH_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign i_ready  = !full && !clear;
  assign i_rsv_id = tail_q;
  assign dispatch = i_valid && i_ready;
  assign count_d  = count_q + (DEPTH_W+1)'(dispatch) - (o_ready ? commit_n : '0);

  // Merge CDB lanes per entry: later lane wins data, exceptions accumulate.
  always_comb begin
    logic [DEPTH_W-1:0] wid;
    wid = '0;
    for (int e = 0; e < DEPTH; e++) begin
      cdb_hit[e]   = 1'b0;
      cdb_exc[e]   = 1'b0;
      cdb_wdata[e] = '0;
    end
    for (int k = 0; k < N_CDB; k++) begin
      wid = cdb_id[k*DEPTH_W +: DEPTH_W];
      if (cdb_valid[k] && valid_q[wid]) begin
        cdb_hit[wid]   = 1'b1;
        cdb_wdata[wid] = cdb_data[k*DATA_W +: DATA_W];
        cdb_exc[wid]   = cdb_exc[wid] | cdb_exception[k];
      end
    end
  end

  always_comb begin
    logic [DEPTH_W-1:0] rid;
    rid       = '0;
    rd_data   = '0;
    rd_filled = '0;
    for (int i = 0; i < N_READ; i++) begin
      rid = rd_id[i*DEPTH_W +: DEPTH_W];
      if (valid_q[rid]) begin
        rd_filled[i]                = ready_q[rid];
        rd_data[i*DATA_W +: DATA_W] = data_q[rid];
        for (int k = 0; k < N_CDB; k++) begin
          if (cdb_valid[k] && (cdb_id[k*DEPTH_W +: DEPTH_W] == rid)) begin
            rd_filled[i]                = 1'b1;
            rd_data[i*DATA_W +: DATA_W] = cdb_data[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Retire lanes form a contiguous prefix that stops after the first exception.
  always_comb begin
    logic [DEPTH_W-1:0] cidx;
    logic               chain;
    cidx        = '0;
    chain       = 1'b1;
    commit_n    = '0;
    o_valid     = '0;
    o_rob_id    = '0;
    o_dst_reg   = '0;
    o_opcode    = '0;
    o_data      = '0;
    o_exception = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      cidx = head_q + DEPTH_W'(j);
      o_rob_id[j*DEPTH_W +: DEPTH_W]        = cidx;
      o_dst_reg[j*REG_ADDR_W +: REG_ADDR_W] = dst_q[cidx];
      o_opcode[j*OPCODE_W +: OPCODE_W]      = op_q[cidx];
      o_data[j*DATA_W +: DATA_W]            = data_q[cidx];
      o_exception[j]                        = exc_q[cidx];
      if (chain && valid_q[cidx] && ready_q[cidx]) begin
        o_valid[j] = 1'b1;
        commit_n   = commit_n + 1'b1;
        chain      = !exc_q[cidx];
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst || clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e] <= 1'b0;
        ready_q[e] <= 1'b0;
        exc_q[e]   <= 1'b0;
        data_q[e]  <= '0;
        dst_q[e]   <= '0;
        op_q[e]    <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (cdb_hit[e]) begin
          ready_q[e] <= 1'b1;
          data_q[e]  <= cdb_wdata[e];
          exc_q[e]   <= exc_q[e] | cdb_exc[e];
        end
      end
      if (o_ready) begin
        for (int j = 0; j < COMMIT_W; j++) begin
          if (o_valid[j]) valid_q[head_q + DEPTH_W'(j)] <= 1'b0;
        end
        head_q <= head_q + commit_n[DEPTH_W-1:0];
      end
      // The tail slot is always invalid when dispatch is allowed, so no CDB/commit overlap.
      if (dispatch) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= i_no_wait;
        exc_q[tail_q]   <= 1'b0;
        data_q[tail_q]  <= '0;
        dst_q[tail_q]   <= i_dst_reg;
        op_q[tail_q]    <= i_opcode;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: directed scenarios then random traffic, all
// compared against an in-order queue model of the in-flight instructions.
module tb_rob_multi_commit;

  localparam int DW  = 2;
  localparam int DEP = 4;
  localparam int XW  = 32;
  localparam int RW  = 6;
  localparam int OW  = 8;
  localparam int NR  = 2;
  localparam int NC  = 2;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             nrst;
  logic             i_valid, i_ready, i_no_wait;
  logic [DW-1:0]    i_rsv_id;
  logic [RW-1:0]    i_dst_reg;
  logic [OW-1:0]    i_opcode;
  logic [NR*DW-1:0] rd_id;
  logic [NR*XW-1:0] rd_data;
  logic [NR-1:0]    rd_filled;
  logic [NC-1:0]    cdb_valid, cdb_exception;
  logic [NC*DW-1:0] cdb_id;
  logic [NC*XW-1:0] cdb_data;
  logic             clear, o_ready;
  logic [CW-1:0]    o_valid, o_exception;
  logic [CW*DW-1:0] o_rob_id;
  logic [CW*RW-1:0] o_dst_reg;
  logic [CW*OW-1:0] o_opcode;
  logic [CW*XW-1:0] o_data;
  logic [DW:0]      count;
  logic             full, empty;

  rob_multi_commit #(
    .DEPTH_W(DW), .DATA_W(XW), .REG_ADDR_W(RW), .OPCODE_W(OW),
    .N_READ(NR), .N_CDB(NC), .COMMIT_W(CW)
  ) dut (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_ready(i_ready), .i_rsv_id(i_rsv_id),
    .i_dst_reg(i_dst_reg), .i_no_wait(i_no_wait), .i_opcode(i_opcode), .rd_id(rd_id),
    .rd_data(rd_data), .rd_filled(rd_filled), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
    .cdb_data(cdb_data), .cdb_exception(cdb_exception), .clear(clear), .o_valid(o_valid),
    .o_ready(o_ready), .o_rob_id(o_rob_id), .o_dst_reg(o_dst_reg), .o_opcode(o_opcode),
    .o_data(o_data), .o_exception(o_exception), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          rdy;
    bit          exc;
    logic [XW-1:0] data;
    logic [RW-1:0] dst;
    logic [OW-1:0] op;
  } ent_t;

  ent_t q[$];
  int   next_id;
  int   n_chk;
  int   n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_id(input int id);
    for (int i = 0; i < q.size(); i++) if (q[i].id == id) return i;
    return -1;
  endfunction

  task automatic idle();
    i_valid = 0; i_no_wait = 0; i_dst_reg = '0; i_opcode = '0; rd_id = '0;
    cdb_valid = '0; cdb_id = '0; cdb_data = '0; cdb_exception = '0;
    clear = 0; o_ready = 0; nrst = 0;
  endtask

  // Compare all outputs to the model, advance the model across the edge, then one clock.
  task automatic cycle();
    int         n;
    bit         chain;
    bit         was_full;
    logic [CW-1:0] exp_v;
    #1;
    check_eq("count", count, q.size());
    check_eq("full", full, q.size() == DEP);
    check_eq("empty", empty, q.size() == 0);
    check_eq("i_ready", i_ready, (q.size() < DEP) && !clear);
    check_eq("i_rsv_id", i_rsv_id, next_id);
    n = 0; chain = 1; exp_v = '0;
    for (int j = 0; j < CW; j++) begin
      if (chain && j < q.size() && q[j].rdy) begin
        exp_v[j] = 1'b1;
        n++;
        chain = !q[j].exc;
        check_eq("o_rob_id", o_rob_id[j*DW +: DW], q[j].id);
        check_eq("o_dst_reg", o_dst_reg[j*RW +: RW], q[j].dst);
        check_eq("o_opcode", o_opcode[j*OW +: OW], q[j].op);
        check_eq("o_data", o_data[j*XW +: XW], q[j].data);
        check_eq("o_exception", o_exception[j], q[j].exc);
      end else begin
        chain = 0;
      end
    end
    check_eq("o_valid", o_valid, exp_v);
    for (int p = 0; p < NR; p++) begin
      int          id, ix;
      bit          ef;
      logic [XW-1:0] ed;
      id = int'(rd_id[p*DW +: DW]);
      ix = find_id(id);
      ef = 0; ed = '0;
      if (ix >= 0) begin
        ef = q[ix].rdy; ed = q[ix].data;
        for (int k = 0; k < NC; k++)
          if (cdb_valid[k] && int'(cdb_id[k*DW +: DW]) == id) begin
            ef = 1; ed = cdb_data[k*XW +: XW];
          end
      end
      check_eq("rd_filled", rd_filled[p], ef);
      check_eq("rd_data", rd_data[p*XW +: XW], ed);
    end
    if (nrst || clear) begin
      q.delete();
      next_id = 0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (cdb_valid[k]) begin
          int ix;
          ix = find_id(int'(cdb_id[k*DW +: DW]));
          if (ix >= 0) begin
            q[ix].rdy  = 1;
            q[ix].data = cdb_data[k*XW +: XW];
            q[ix].exc  = q[ix].exc | cdb_exception[k];
          end
        end
      end
      was_full = (q.size() == DEP);
      if (o_ready) repeat (n) void'(q.pop_front());
      if (i_valid && !was_full) begin
        ent_t e;
        e.id = next_id; e.rdy = i_no_wait; e.exc = 0; e.data = '0;
        e.dst = i_dst_reg; e.op = i_opcode;
        q.push_back(e);
        next_id = (next_id + 1) % DEP;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; next_id = 0;
    idle();
    nrst = 1;
    repeat (3) @(posedge clk);
    #1;
    nrst = 0;
    check_eq("rst_i_ready", i_ready, 1);
    check_eq("rst_rsv_id", i_rsv_id, 0);
    check_eq("rst_o_valid", o_valid, 0);
    check_eq("rst_rd_filled", rd_filled, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);

    // Fill the buffer with waiting entries.
    for (int i = 0; i < DEP; i++) begin
      idle();
      i_valid = 1; i_dst_reg = RW'(i + 1); i_opcode = OW'(8'h10 + i);
      check_eq("dir_rsv_id", i_rsv_id, i);
      cycle();
    end
    idle();
    check_eq("dir_full", full, 1);
    check_eq("dir_full_rdy", i_ready, 0);
    check_eq("dir_full_cnt", count, 4);
    i_valid = 1;
    cycle();
    idle();
    check_eq("dir_5th_cnt", count, 4);
    check_eq("dir_5th_tail", i_rsv_id, 0);

    // Out-of-order completion, then dual retire.
    cdb_valid = 2'b01; cdb_id = {2'd0, 2'd1}; cdb_data = {32'h0, 32'hAA};
    cycle();
    cdb_id = {2'd0, 2'd0}; cdb_data = {32'h0, 32'h55};
    cycle();
    idle();
    check_eq("dir_two_valid", o_valid, 2'b11);
    check_eq("dir_two_data", o_data, {32'hAA, 32'h55});
    o_ready = 1;
    cycle();
    idle();
    check_eq("dir_two_cnt", count, 2);

    // Both lanes to id 3: lane 1 data wins, lane 0 exception sticks.
    cdb_valid = 2'b11; cdb_id = {2'd3, 2'd3}; cdb_data = {32'h2, 32'h1};
    cdb_exception = 2'b01;
    cycle();
    idle();
    rd_id = {2'd1, 2'd3};
    #1;
    check_eq("dir_same_data", rd_data[XW-1:0], 32'h2);
    check_eq("dir_same_fill", rd_filled, 2'b01);
    check_eq("dir_inv_data", rd_data[2*XW-1:XW], 0);
    cdb_valid = 2'b10; cdb_id = {2'd2, 2'd0}; cdb_data = {32'h7, 32'h0};
    cycle();
    idle();
    check_eq("dir_exc_valid", o_valid, 2'b11);
    check_eq("dir_exc_flag", o_exception, 2'b10);
    clear = 1;
    cycle();
    idle();
    check_eq("dir_clr_empty", empty, 1);
    check_eq("dir_clr_tail", i_rsv_id, 0);

    for (int c = 0; c < 4000; c++) begin
      i_valid       = ($urandom_range(0, 3) != 0);
      i_no_wait     = ($urandom_range(0, 3) == 0);
      i_dst_reg     = RW'($urandom);
      i_opcode      = OW'($urandom);
      rd_id         = NR*DW'($urandom);
      cdb_valid     = NC'($urandom);
      cdb_id        = NC*DW'($urandom);
      cdb_data      = {$urandom, $urandom};
      cdb_exception = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      clear         = ($urandom_range(0, 39) == 0);
      o_ready       = clear ? 1'b0 : ($urandom_range(0, 3) != 0);
      nrst          = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
